// File: rtl/id_pkg.sv
// id_pkg: shared constants for the MIPS32 ID stage.
//   - opcode / func field encodings of the decoded subset
//   - aluop / alusel codes handed to EX
//   - NOP destination and link register indices
//   - immediate-kind enum used by the decoder
package id_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_PREF    = 6'h33;

    // SPECIAL func codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_SYNC = 6'h0F;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    // aluop codes
    localparam logic [7:0] ALU_NOP  = 8'h00;
    localparam logic [7:0] ALU_AND  = 8'h24;
    localparam logic [7:0] ALU_OR   = 8'h25;
    localparam logic [7:0] ALU_XOR  = 8'h26;
    localparam logic [7:0] ALU_NOR  = 8'h27;
    localparam logic [7:0] ALU_SLL  = 8'h7C;
    localparam logic [7:0] ALU_SRL  = 8'h02;
    localparam logic [7:0] ALU_SRA  = 8'h03;
    localparam logic [7:0] ALU_ADDU = 8'h21;
    localparam logic [7:0] ALU_JR   = 8'h08;
    localparam logic [7:0] ALU_J    = 8'h4F;
    localparam logic [7:0] ALU_JAL  = 8'h50;
    localparam logic [7:0] ALU_BEQ  = 8'h51;
    localparam logic [7:0] ALU_BNE  = 8'h52;

    // alusel codes (result class picked in EX)
    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd4;
    localparam logic [2:0] SEL_JUMP  = 3'd6;

    localparam logic [4:0] NOP_REG_ADDR = 5'd0;
    localparam logic [4:0] LINK_REG     = 5'd31;

    // How the immediate operand is formed
    typedef enum logic [2:0] {
        IMM_ZERO,
        IMM_ZEXT,
        IMM_SEXT,
        IMM_LUI,
        IMM_SA
    } imm_kind_e;

endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: resolves one source operand.
//   rd_en / addr      : operand read enable and register address
//   rf_data / imm     : register-file data and immediate fallback
//   fwd_*             : packed forwarding sources, index 0 = youngest
//   data              : resolved operand
//   load_hit          : winning forward source holds a not-yet-ready load
module id_fwd_mux #(
    parameter int NUM_FWD = 2,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5
) (
    input  logic                      rd_en,
    input  logic [REG_AW-1:0]         addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [DATA_W-1:0]         imm,
    input  logic [NUM_FWD-1:0]        fwd_wreg,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    output logic [DATA_W-1:0]         data,
    output logic                      load_hit
);

    always_comb begin
        data     = rf_data;
        load_hit = 1'b0;
        if (!rd_en) begin
            data = imm;
        end else if (addr == '0) begin
            // $0 is hard-wired; a write to it in flight must not leak through
            data = '0;
        end else begin
            // Scan oldest to youngest so the lowest matching index wins last
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_wreg[k] && fwd_wd[k*REG_AW +: REG_AW] == addr) begin
                    data     = fwd_wdata[k*DATA_W +: DATA_W];
                    load_hit = fwd_is_load[k];
                end
            end
        end
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS32 instruction decode with forwarding, load-use detection,
// branch resolution and the ID/EX pipeline register.
//   pc_i, inst_i              : instruction in ID
//   stall_i, flush_i          : downstream hold / bubble (flush wins)
//   reg1/2_data_i             : register-file read data
//   fwd_*_i                   : NUM_FWD forwarding sources, 0 = youngest
//   reg1/2_read_o, _addr_o    : register-file read port control
//   stallreq_o                : load-use stall request
//   branch_flag_o/_target_o   : fetch redirect
//   ex_*                      : registered ID/EX outputs
module id_stage
    import id_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_FWD  = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         pc_i,
    input  logic [31:0]               inst_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [DATA_W-1:0]         reg1_data_i,
    input  logic [DATA_W-1:0]         reg2_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_is_load_i,
    output logic                      reg1_read_o,
    output logic                      reg2_read_o,
    output logic [REG_AW-1:0]         reg1_addr_o,
    output logic [REG_AW-1:0]         reg2_addr_o,
    output logic                      stallreq_o,
    output logic                      branch_flag_o,
    output logic [DATA_W-1:0]         branch_target_o,
    output logic [ALUOP_W-1:0]        ex_aluop_o,
    output logic [ALUSEL_W-1:0]       ex_alusel_o,
    output logic [DATA_W-1:0]         ex_reg1_o,
    output logic [DATA_W-1:0]         ex_reg2_o,
    output logic [REG_AW-1:0]         ex_wd_o,
    output logic                      ex_wreg_o,
    output logic [DATA_W-1:0]         ex_link_addr_o,
    output logic                      ex_in_delayslot_o,
    output logic                      ex_inst_invalid_o
);

    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;
    logic [25:0] idx;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign func  = inst_i[5:0];
    assign imm16 = inst_i[15:0];
    assign idx   = inst_i[25:0];

    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [REG_AW-1:0]   wd;
    logic                wreg, rd1, rd2, inv;
    logic                is_beq, is_bne, is_j, is_jr, is_link;
    imm_kind_e           imm_kind;

    always_comb begin
        aluop    = ALUOP_W'(ALU_NOP);
        alusel   = ALUSEL_W'(SEL_NOP);
        wd       = REG_AW'(NOP_REG_ADDR);
        wreg     = 1'b0;
        rd1      = 1'b0;
        rd2      = 1'b0;
        inv      = 1'b1;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        is_link  = 1'b0;
        imm_kind = IMM_ZERO;
        case (op)
            OP_SPECIAL: begin
                case (func)
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_ADDU,
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        rd1  = 1'b1;
                        rd2  = 1'b1;
                        wreg = 1'b1;
                        wd   = REG_AW'(rd);
                        inv  = 1'b0;
                        case (func)
                            FN_AND:  begin aluop = ALUOP_W'(ALU_AND);  alusel = ALUSEL_W'(SEL_LOGIC); end
                            FN_OR:   begin aluop = ALUOP_W'(ALU_OR);   alusel = ALUSEL_W'(SEL_LOGIC); end
                            FN_XOR:  begin aluop = ALUOP_W'(ALU_XOR);  alusel = ALUSEL_W'(SEL_LOGIC); end
                            FN_NOR:  begin aluop = ALUOP_W'(ALU_NOR);  alusel = ALUSEL_W'(SEL_LOGIC); end
                            FN_ADDU: begin aluop = ALUOP_W'(ALU_ADDU); alusel = ALUSEL_W'(SEL_ARITH); end
                            FN_SLLV: begin aluop = ALUOP_W'(ALU_SLL);  alusel = ALUSEL_W'(SEL_SHIFT); end
                            FN_SRLV: begin aluop = ALUOP_W'(ALU_SRL);  alusel = ALUSEL_W'(SEL_SHIFT); end
                            default: begin aluop = ALUOP_W'(ALU_SRA);  alusel = ALUSEL_W'(SEL_SHIFT); end
                        endcase
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // sa travels as operand 1 so EX uses one shifter for both forms
                        rd2      = 1'b1;
                        imm_kind = IMM_SA;
                        wreg     = 1'b1;
                        wd       = REG_AW'(rd);
                        inv      = 1'b0;
                        alusel   = ALUSEL_W'(SEL_SHIFT);
                        case (func)
                            FN_SLL:  aluop = ALUOP_W'(ALU_SLL);
                            FN_SRL:  aluop = ALUOP_W'(ALU_SRL);
                            default: aluop = ALUOP_W'(ALU_SRA);
                        endcase
                    end
                    FN_JR: begin
                        rd1   = 1'b1;
                        is_jr = 1'b1;
                        aluop = ALUOP_W'(ALU_JR);
                        inv   = 1'b0;
                    end
                    FN_SYNC: inv = 1'b0;
                    default: ;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_ADDIU: begin
                rd1    = 1'b1;
                wreg   = 1'b1;
                wd     = REG_AW'(rt);
                inv    = 1'b0;
                alusel = ALUSEL_W'(SEL_LOGIC);
                case (op)
                    OP_ANDI: begin aluop = ALUOP_W'(ALU_AND); imm_kind = IMM_ZEXT; end
                    OP_ORI:  begin aluop = ALUOP_W'(ALU_OR);  imm_kind = IMM_ZEXT; end
                    OP_XORI: begin aluop = ALUOP_W'(ALU_XOR); imm_kind = IMM_ZEXT; end
                    // LUI is rs | (imm << 16); rs is $0 in a well-formed encoding
                    OP_LUI:  begin aluop = ALUOP_W'(ALU_OR);  imm_kind = IMM_LUI;  end
                    default: begin
                        aluop    = ALUOP_W'(ALU_ADDU);
                        alusel   = ALUSEL_W'(SEL_ARITH);
                        imm_kind = IMM_SEXT;
                    end
                endcase
            end
            OP_BEQ, OP_BNE: begin
                rd1    = 1'b1;
                rd2    = 1'b1;
                inv    = 1'b0;
                is_beq = (op == OP_BEQ);
                is_bne = (op == OP_BNE);
                aluop  = (op == OP_BEQ) ? ALUOP_W'(ALU_BEQ) : ALUOP_W'(ALU_BNE);
            end
            OP_J: begin
                is_j  = 1'b1;
                aluop = ALUOP_W'(ALU_J);
                inv   = 1'b0;
            end
            OP_JAL: begin
                is_j    = 1'b1;
                is_link = 1'b1;
                wreg    = 1'b1;
                wd      = REG_AW'(LINK_REG);
                aluop   = ALUOP_W'(ALU_JAL);
                alusel  = ALUSEL_W'(SEL_JUMP);
                inv     = 1'b0;
            end
            OP_PREF: inv = 1'b0;
            default: ;
        endcase
    end

    logic [DATA_W-1:0] imm;

    always_comb begin
        case (imm_kind)
            IMM_ZEXT: imm = {{(DATA_W-16){1'b0}}, imm16};
            IMM_SEXT: imm = {{(DATA_W-16){imm16[15]}}, imm16};
            IMM_LUI:  imm = {imm16, {(DATA_W-16){1'b0}}};
            IMM_SA:   imm = {{(DATA_W-5){1'b0}}, sa};
            default:  imm = '0;
        endcase
    end

    assign reg1_read_o = rd1;
    assign reg2_read_o = rd2;
    assign reg1_addr_o = REG_AW'(rs);
    assign reg2_addr_o = REG_AW'(rt);

    logic [DATA_W-1:0] op1, op2;
    logic              ld1, ld2;

    id_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
        .rd_en       (rd1),
        .addr        (REG_AW'(rs)),
        .rf_data     (reg1_data_i),
        .imm         (imm),
        .fwd_wreg    (fwd_wreg_i),
        .fwd_wd      (fwd_wd_i),
        .fwd_wdata   (fwd_wdata_i),
        .fwd_is_load (fwd_is_load_i),
        .data        (op1),
        .load_hit    (ld1)
    );

    id_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
        .rd_en       (rd2),
        .addr        (REG_AW'(rt)),
        .rf_data     (reg2_data_i),
        .imm         (imm),
        .fwd_wreg    (fwd_wreg_i),
        .fwd_wd      (fwd_wd_i),
        .fwd_wdata   (fwd_wdata_i),
        .fwd_is_load (fwd_is_load_i),
        .data        (op2),
        .load_hit    (ld2)
    );

    assign stallreq_o = ld1 | ld2;

    // Branch resolution
    logic [DATA_W-1:0] pc4, pc8, br_off;
    logic              taken, is_br;

    assign pc4    = pc_i + DATA_W'(4);
    assign pc8    = pc_i + DATA_W'(8);
    assign br_off = {{(DATA_W-18){imm16[15]}}, imm16, 2'b00};
    assign is_br  = is_beq | is_bne | is_j | is_jr;
    assign taken  = (is_beq & (op1 == op2)) | (is_bne & (op1 != op2)) | is_j | is_jr;

    // A stalled branch must not redirect: its operands may still be stale
    assign branch_flag_o   = taken & ~stallreq_o;
    assign branch_target_o = is_jr ? op1 :
                             is_j  ? {pc4[DATA_W-1:28], idx, 2'b00} :
                                     pc4 + br_off;

    // ID/EX register; ds_next marks that the next captured instruction
    // sits in a branch delay slot
    logic ds_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_i) begin
            ex_aluop_o        <= '0;
            ex_alusel_o       <= '0;
            ex_reg1_o         <= '0;
            ex_reg2_o         <= '0;
            ex_wd_o           <= '0;
            ex_wreg_o         <= 1'b0;
            ex_link_addr_o    <= '0;
            ex_in_delayslot_o <= 1'b0;
            ex_inst_invalid_o <= 1'b0;
            ds_next           <= 1'b0;
        end else if (stall_i) begin
            // hold everything
        end else if (stallreq_o) begin
            // load-use bubble; ds_next kept for when the instruction retries
            ex_aluop_o        <= '0;
            ex_alusel_o       <= '0;
            ex_reg1_o         <= '0;
            ex_reg2_o         <= '0;
            ex_wd_o           <= '0;
            ex_wreg_o         <= 1'b0;
            ex_link_addr_o    <= '0;
            ex_in_delayslot_o <= 1'b0;
            ex_inst_invalid_o <= 1'b0;
        end else begin
            ex_aluop_o        <= aluop;
            ex_alusel_o       <= alusel;
            ex_reg1_o         <= op1;
            ex_reg2_o         <= op2;
            ex_wd_o           <= wd;
            ex_wreg_o         <= wreg;
            ex_link_addr_o    <= is_link ? pc8 : '0;
            ex_in_delayslot_o <= ds_next;
            ex_inst_invalid_o <= inv;
            ds_next           <= is_br;
        end
    end

endmodule
